// File: rtl/ccta_pkg.sv
// Shared constants for the conditional compute-and-tally block.
package ccta_pkg;
   localparam int DATA_W_DEFAULT = 4;
   localparam int OUT_W          = DATA_W_DEFAULT + 1;
   localparam int SAT_MAX        = (1 << OUT_W) - 1;

   localparam logic MODE_SUM  = 1'b0;
   localparam logic MODE_DIFF = 1'b1;
endpackage

// File: rtl/ccta_alu.sv
// Combinational core of ccta.
// Computes A+B+C (sum mode) or |A-B|+C (difference mode).
// The arithmetic runs wide enough that nothing is lost, then clamps to the
// largest value the output can hold.
module ccta_alu
   import ccta_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic              ctrl,
   output logic [DATA_W:0]   r
);
   localparam int WIDE_W = DATA_W + 2;
   localparam logic [WIDE_W-1:0] SAT_W = WIDE_W'((1 << (DATA_W + 1)) - 1);

   logic [DATA_W-1:0] diff;
   logic [WIDE_W-1:0] first;
   logic [WIDE_W-1:0] wide;

   // Select the first term: the ordered difference never wraps, the pair sum
   // is widened before adding. Then add C and clamp at the output maximum.
   always_comb begin
      diff  = (a >= b) ? (a - b) : (b - a);
      first = (ctrl == MODE_DIFF) ? {2'b00, diff}
                                  : ({2'b00, a} + {2'b00, b});
      wide  = first + {2'b00, c};
      r     = (wide > SAT_W) ? SAT_W[DATA_W:0] : wide[DATA_W:0];
   end
endmodule

// File: rtl/ccta.sv
// Conditional compute-and-tally block.
// Two-stage pipeline: the operands and mode are registered first. The clamped
// result of that sample is registered one edge later.
module ccta
   import ccta_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] C,
   input  logic              ctrl,
   output logic [DATA_W:0]   q
);
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] c_reg;
   logic              ctrl_reg;
   logic [DATA_W:0]   r_next;

   // Stage 1: capture operands and mode together so a mode change applies to
   // exactly that sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         c_reg    <= '0;
         ctrl_reg <= MODE_SUM;
      end else begin
         a_reg    <= A;
         b_reg    <= B;
         c_reg    <= C;
         ctrl_reg <= ctrl;
      end
   end

   ccta_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a    (a_reg),
      .b    (b_reg),
      .c    (c_reg),
      .ctrl (ctrl_reg),
      .r    (r_next)
   );

   // Stage 2: register the clamped result. It clears at once on reset, so
   // samples already in flight are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= r_next;
      end
   end
endmodule

// File: tb/tb_ccta.sv
// Self-checking bench for ccta.
// A reference model predicts the output from the arithmetic rules, and the
// output is compared with it on every falling edge. Directed samples also
// carry hand-computed literal expectations.
module tb_ccta;
   localparam int DW  = 4;
   localparam int SAT = (1 << (DW + 1)) - 1;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] A;
   logic [DW-1:0] B;
   logic [DW-1:0] C;
   logic          ctrl;
   logic [DW:0]   q;

   int checks = 0;
   int passes = 0;
   int edge_cnt = 0;
   bit model_en = 0;

   // Reference state: the value expected on q now, and the value the
   // sample captured at the last edge will produce.
   int exp_q = 0;
   int pending = 0;

   // Literal expectations: the edge count at which each value is due on q.
   int lit_due[$];
   int lit_val[$];

   ccta #(.DATA_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .C     (C),
      .ctrl  (ctrl),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_f(input int a, input int b, input int c, input int m);
      int r;
      if (m != 0) r = ((a >= b) ? (a - b) : (b - a)) + c;
      else        r = a + b + c;
      return (r > SAT) ? SAT : r;
   endfunction

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got == want) passes++;
      else $display("FAIL %s: q=%0d expected=%0d at t=%0t", name, got, want, $time);
   endtask

   // Model update on each rising edge. A sample shows on q one edge after
   // the edge that captures it.
   always @(posedge clk) begin
      edge_cnt++;
      if (!rst_n) begin
         exp_q   = 0;
         pending = 0;
      end else begin
         exp_q   = pending;
         pending = ref_f(int'(A), int'(B), int'(C), int'(ctrl));
      end
   end

   // Asserting reset drops everything in flight immediately.
   always @(negedge rst_n) begin
      exp_q   = 0;
      pending = 0;
   end

   // Compare the output with the model on every falling edge, and check any
   // literal expectation that falls due on this edge.
   always @(negedge clk) begin
      if (model_en) check("model_q", int'(q), exp_q);
      while (lit_due.size() > 0 && lit_due[0] <= edge_cnt) begin
         check("literal_q", int'(q), lit_val[0]);
         void'(lit_due.pop_front());
         void'(lit_val.pop_front());
      end
   end

   task automatic drive(input int a, input int b, input int c, input int m);
      @(negedge clk);
      A    = DW'(a);
      B    = DW'(b);
      C    = DW'(c);
      ctrl = m[0];
   endtask

   task automatic drive_lit(input int a, input int b, input int c, input int m, input int want);
      drive(a, b, c, m);
      lit_due.push_back(edge_cnt + 2);
      lit_val.push_back(want);
      $display("sample A=%0d B=%0d C=%0d ctrl=%0d expect q=%0d", a, b, c, m, want);
   endtask

   initial begin
      rst_n = 1'b1;
      A = 4'd4; B = 4'd1; C = 4'd9; ctrl = 1'b0;
      #1 rst_n = 1'b0;
      #1 model_en = 1;

      // Pin the model against hand-computed values.
      check("ref_sum_sat", ref_f(13, 6, 13, 0), 31);
      check("ref_diff_rev", ref_f(5, 7, 2, 1), 4);
      check("ref_diff_max", ref_f(0, 15, 15, 1), 30);

      // Hold reset for two cycles, then release. The first sample gives 14.
      repeat (2) @(negedge clk);
      check("reset_q", int'(q), 0);
      rst_n = 1'b1;
      lit_due.push_back(edge_cnt + 2);
      lit_val.push_back(14);
      $display("reset release A=4 B=1 C=9 ctrl=0 expect q=14");
      @(negedge clk);

      // Sum stream.
      drive_lit(3, 13, 13, 0, 29);
      drive_lit(5, 2, 1, 0, 8);
      drive_lit(13, 6, 13, 0, 31);
      drive_lit(13, 12, 9, 0, 31);
      // Difference stream.
      drive_lit(6, 5, 10, 1, 11);
      drive_lit(5, 7, 2, 1, 4);
      drive_lit(15, 2, 14, 1, 27);
      drive_lit(8, 5, 12, 1, 15);
      drive_lit(13, 13, 5, 1, 5);
      drive_lit(3, 10, 0, 1, 7);
      // Mode switching with fixed operands.
      for (int i = 0; i < 6; i++) drive_lit(15, 15, 15, i % 2, (i % 2) ? 15 : 31);
      // Boundaries.
      drive_lit(0, 0, 0, 0, 0);
      drive_lit(15, 15, 1, 0, 31);
      drive_lit(0, 15, 15, 1, 30);

      // Random stream.
      for (int i = 0; i < 300; i++)
         drive(int'($urandom_range(15)), int'($urandom_range(15)),
               int'($urandom_range(15)), int'($urandom_range(1)));
      repeat (3) @(negedge clk);

      // Mid-stream reset with a full pipeline, asserted between clock edges.
      drive(15, 15, 15, 0);
      drive(9, 2, 7, 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset_q", int'(q), 0);
      $display("mid-stream reset asserted, expect q=0");
      @(negedge clk);
      rst_n = 1'b1;
      A = '0; B = '0; C = '0; ctrl = 1'b0;
      // After release q must stay zero: the samples dropped by reset must not
      // reappear.
      repeat (2) begin
         @(posedge clk);
         #1 check("post_reset_q", int'(q), 0);
      end
      for (int i = 0; i < 50; i++)
         drive(int'($urandom_range(15)), int'($urandom_range(15)),
               int'($urandom_range(15)), int'($urandom_range(1)));
      repeat (4) @(negedge clk);

      if (lit_due.size() != 0) check("literal_drain", lit_due.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
